// File: rtl/parity_packer.sv
// Packs qualified parity bits LSB-first into WIDTH-bit words and queues them
// in a DEPTH-entry FIFO with a valid/ready output and a sticky overflow flag.
module parity_packer #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     bit_in,
  input  logic                     bit_valid,
  output logic [WIDTH-1:0]         word_out,
  output logic                     word_valid,
  input  logic                     word_ready,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic [$clog2(WIDTH)-1:0] bit_pos,
  output logic                     overflow,
  input  logic                     clr_ovf
);

  localparam int PW = $clog2(WIDTH);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [PW-1:0] LAST_POS = PW'(WIDTH - 1);
  localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

  logic [WIDTH-1:0] acc_q, acc_d;
  logic [PW-1:0]    pos_q, pos_d;
  logic [AW-1:0]    wr_q, wr_d;
  logic [AW-1:0]    rd_q, rd_d;
  logic [LW-1:0]    lvl_q, lvl_d;
  logic             ovf_q, ovf_d;
  logic [WIDTH-1:0] mem_q [DEPTH];

  logic [WIDTH-1:0] new_word;
  logic             complete;
  logic             full;
  logic             pop;
  logic             push;
  logic             drop;

  always_comb begin
    acc_d    = acc_q;
    pos_d    = pos_q;
    complete = 1'b0;
    new_word = {bit_in, acc_q[WIDTH-2:0]};
    if (bit_valid) begin
      if (pos_q == LAST_POS) begin
        complete = 1'b1;
        acc_d    = '0;
        pos_d    = '0;
      end else begin
        acc_d[pos_q] = bit_in;
        pos_d        = pos_q + PW'(1);
      end
    end
  end

  // A pop on the same edge frees a slot, so a completing word is never
  // dropped while the consumer is draining.
  always_comb begin
    full = (lvl_q == FULL_LVL);
    pop  = word_valid && word_ready;
    push = complete && (!full || pop);
    drop = complete && full && !pop;

    wr_d = push ? wr_q + AW'(1) : wr_q;
    rd_d = pop  ? rd_q + AW'(1) : rd_q;

    case ({push, pop})
      2'b10:   lvl_d = lvl_q + LW'(1);
      2'b01:   lvl_d = lvl_q - LW'(1);
      default: lvl_d = lvl_q;
    endcase

    if (drop)         ovf_d = 1'b1;
    else if (clr_ovf) ovf_d = 1'b0;
    else              ovf_d = ovf_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_q <= '0;
      pos_q <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      lvl_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      pos_q <= pos_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      lvl_q <= lvl_d;
      ovf_q <= ovf_d;
    end
  end

  // Storage needs no reset: entries are only visible once written.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= new_word;
  end

  assign word_valid = (lvl_q != '0);
  assign word_out   = word_valid ? mem_q[rd_q] : '0;
  assign fifo_level = lvl_q;
  assign bit_pos    = pos_q;
  assign overflow   = ovf_q;

endmodule

// File: tb/tb_parity_packer.sv
// Scoreboard bench for parity_packer: a bit-queue/word-queue reference model
// predicts every word, level, bit position and overflow state.
module tb_parity_packer;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             bit_in = 1'b0;
  logic             bit_valid = 1'b0;
  logic             word_ready = 1'b0;
  logic             clr_ovf = 1'b0;
  logic [WIDTH-1:0] word_out;
  logic             word_valid;
  logic [$clog2(DEPTH):0]   fifo_level;
  logic [$clog2(WIDTH)-1:0] bit_pos;
  logic             overflow;

  parity_packer #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .bit_in     (bit_in),
    .bit_valid  (bit_valid),
    .word_out   (word_out),
    .word_valid (word_valid),
    .word_ready (word_ready),
    .fifo_level (fifo_level),
    .bit_pos    (bit_pos),
    .overflow   (overflow),
    .clr_ovf    (clr_ovf)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  logic [WIDTH-1:0] exp_q[$];
  bit               m_bits[$];
  int               m_level = 0;
  bit               m_ovf = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: evaluated at the falling edge for the rising edge ahead.
  always @(negedge clk) begin
    bit          pop;
    bit          drop;
    logic [31:0] w;
    if (!rst) begin
      m_bits.delete();
      exp_q.delete();
      m_level = 0;
      m_ovf   = 1'b0;
      chk("rst_word_valid", 32'(word_valid), 0);
      chk("rst_word_out",   32'(word_out),   0);
      chk("rst_fifo_level", 32'(fifo_level), 0);
      chk("rst_bit_pos",    32'(bit_pos),    0);
      chk("rst_overflow",   32'(overflow),   0);
    end else begin
      chk("fifo_level", 32'(fifo_level), 32'(m_level));
      chk("overflow",   32'(overflow),   32'(m_ovf));
      chk("bit_pos",    32'(bit_pos),    32'(m_bits.size()));
      chk("word_valid", 32'(word_valid), 32'(m_level > 0));
      pop  = (m_level > 0) && word_ready;
      drop = 1'b0;
      if (bit_valid) begin
        m_bits.push_back(bit_in);
        if (m_bits.size() == WIDTH) begin
          w = 0;
          for (int i = 0; i < WIDTH; i++) w = w + (m_bits[i] ? (32'd1 << i) : 32'd0);
          m_bits.delete();
          if (m_level < DEPTH || pop) begin
            exp_q.push_back(w[WIDTH-1:0]);
            m_level++;
          end else begin
            drop = 1'b1;
          end
        end
      end
      if (pop) m_level--;
      if (drop)         m_ovf = 1'b1;
      else if (clr_ovf) m_ovf = 1'b0;
    end
  end

  // Monitor: consumes expected words whenever the DUT hands one over.
  always @(negedge clk) begin
    logic [WIDTH-1:0] e;
    #1;
    if (rst) begin
      if (word_valid) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_word: got 0x%0h, expected no word (t=%0t)", word_out, $time);
        end else if (word_ready) begin
          e = exp_q.pop_front();
          chk("word_out", 32'(word_out), 32'(e));
        end else begin
          chk("word_out_hold", 32'(word_out), 32'(exp_q[0]));
        end
      end else begin
        chk("word_out_idle", 32'(word_out), 0);
      end
    end
  end

  task automatic drive(input bit b, input bit v, input bit r, input bit c);
    @(posedge clk);
    #1;
    bit_in     = b;
    bit_valid  = v;
    word_ready = r;
    clr_ovf    = c;
  endtask

  task automatic idle(input int n, input bit r);
    repeat (n) drive(1'b0, 1'b0, r, 1'b0);
  endtask

  task automatic send_word(input logic [WIDTH-1:0] w, input bit r, input bit r_last,
                           input bit c_last, input int gap_a, input int gap_b, input int gap_len);
    for (int i = 0; i < WIDTH; i++) begin
      if (i == WIDTH - 1) drive(w[i], 1'b1, r_last, c_last);
      else                drive(w[i], 1'b1, r, 1'b0);
      if (i + 1 == gap_a || i + 1 == gap_b) repeat (gap_len) drive(1'b0, 1'b0, r, 1'b0);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: got no finish, expected finish before 2ms");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b0;
    repeat (5) drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                     1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    chk("hold_rst_valid", 32'(word_valid), 0);
    chk("hold_rst_pos",   32'(bit_pos),    0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    bit_valid = 1'b0;
    clr_ovf   = 1'b0;

    send_word(8'hA5, 1'b1, 1'b1, 1'b0, 0, 0, 0);
    idle(3, 1'b1);
    send_word(8'hA5, 1'b1, 1'b1, 1'b0, 2, 5, 3);
    idle(3, 1'b1);

    for (int k = 1; k <= 5; k++) send_word(8'(k), 1'b0, 1'b0, 1'b0, 0, 0, 0);
    idle(2, 1'b0);
    chk("fill_level", 32'(fifo_level), 4);
    chk("fill_ovf",   32'(overflow),   1);
    idle(8, 1'b1);

    drive(1'b0, 1'b0, 1'b0, 1'b1);
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < DEPTH; k++) send_word(8'($urandom), 1'b0, 1'b0, 1'b0, 0, 0, 0);
    send_word(8'h3C, 1'b0, 1'b1, 1'b0, 0, 0, 0);
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    chk("full_pop_level", 32'(fifo_level), 4);
    chk("full_pop_ovf",   32'(overflow),   0);
    idle(8, 1'b1);

    for (int k = 0; k < DEPTH; k++) send_word(8'($urandom), 1'b0, 1'b0, 1'b0, 0, 0, 0);
    send_word(8'h77, 1'b0, 1'b0, 1'b1, 0, 0, 0);
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    chk("set_beats_clr", 32'(overflow), 1);
    drive(1'b0, 1'b0, 1'b0, 1'b1);
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    chk("clr_alone", 32'(overflow), 0);
    idle(8, 1'b1);

    for (int k = 0; k < 5; k++) drive(1'b1, 1'b1, 1'b1, 1'b0);
    @(posedge clk);
    #2;
    chk("pre_rst_pos", 32'(bit_pos), 5);
    rst = 1'b0;
    #1;
    chk("async_rst_pos",   32'(bit_pos),    0);
    chk("async_rst_valid", 32'(word_valid), 0);
    chk("async_rst_out",   32'(word_out),   0);
    bit_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    send_word(8'hFF, 1'b1, 1'b1, 1'b0, 0, 0, 0);
    idle(3, 1'b1);

    for (int blk = 0; blk < 6; blk++) begin
      int rdy_pct;
      rdy_pct = (blk % 3 == 0) ? 20 : ((blk % 3 == 1) ? 60 : 100);
      repeat (500)
        drive(1'($urandom_range(0, 1)),
              1'($urandom_range(0, 9) < 7),
              1'($urandom_range(1, 100) <= rdy_pct),
              1'($urandom_range(0, 63) == 0));
    end

    idle(3 * DEPTH, 1'b1);
    chk("scoreboard_empty", 32'(exp_q.size()), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/parity_packer.md
# parity_packer

Downstream stage of the add-and-parity pipeline. It takes the single registered parity bit that the pipeline produces each cycle and packs consecutive qualified bits, LSB first, into WIDTH-bit words. Completed words go into a DEPTH-entry FIFO and leave through a valid/ready handshake. A sticky flag records any word lost to a full FIFO.

## Interface
- WIDTH, 8: bits packed per output word (≥2).
- DEPTH, 4: FIFO entries (power of two, ≥2).
- clk  input  1  single clock; all state updates on its rising edge.
- rst  input  1  asynchronous, active-low reset; clears all state immediately.
- bit_in  input  1  parity bit from the upstream stage's data_out.
- bit_valid  input  1  bit_in is sampled on a rising edge only when this is high.
- word_out  output  WIDTH  FIFO head word; 0 when the FIFO is empty.
- word_valid  output  1  high whenever the FIFO is non-empty.
- word_ready  input  1  consumer accepts the head word on an edge where word_valid && word_ready.
- fifo_level  output  $clog2(DEPTH)+1  number of stored words, 0..DEPTH.
- bit_pos  output  $clog2(WIDTH)  number of bits already packed into the word in progress.
- overflow  output  1  sticky; set when a completed word is dropped.
- clr_ovf  input  1  synchronous clear of overflow.

## Operation
- Packing: shift register `acc` and counter `bit_pos`. On an edge with bit_valid=1, bit_in is written to acc[bit_pos] and bit_pos increments. The first accepted bit of a word becomes word bit 0.
- Word completion: when bit_valid=1 and bit_pos=WIDTH-1, the word {bit_in, acc[WIDTH-2:0]} is pushed on the same edge. bit_pos wraps to 0 and acc clears to 0.
- bit_valid=0 holds acc and bit_pos. Gaps of any length are allowed inside a word.
- FIFO: circular buffer with read and write pointers plus a level counter.
  - Push happens on word completion.
  - Pop happens on word_valid && word_ready.
  - word_out and word_valid are taken from the head entry and level, with no combinational path from bit_in.
- Simultaneous push and pop: both take effect and the level is unchanged. This holds when the FIFO is full: the pop frees a slot, the push is accepted, and overflow is not set.
- Push when full without a pop: the word is discarded and overflow is set. FIFO contents, pointers and level are unchanged. The packer continues with bit_pos=0.
- Pop when empty is impossible, because word_valid=0.
- overflow: set has priority over clr_ovf on the same edge. Otherwise clr_ovf=1 clears it. The flag holds until cleared or reset.
- Reset (rst=0, asynchronous, any time including mid-word or mid-handshake):
  - acc=0, bit_pos=0, pointers=0, fifo_level=0.
  - word_valid=0, word_out=0, overflow=0.
  - A partial word is discarded.
  - The first edge after rst deasserts starts a fresh word.

## Timing
- Reset values of outputs: word_out=0, word_valid=0, fifo_level=0, bit_pos=0, overflow=0.
- Latency: if the FIFO is empty, word_valid rises directly after the edge that samples the WIDTH-th bit, and word_out shows the word in that same cycle. That is one cycle from the last bit_in presentation to word_valid.
- Throughput: one bit per cycle in. With word_ready held high, one word per WIDTH cycles out and no overflow is possible.
- word_out and word_valid stay stable while word_valid=1 and word_ready=0.
- After a pop, the next head word appears one edge later. word_valid stays high back-to-back if level was ≥2.
- fifo_level and overflow are registered and update on the same edge as the push or pop that changes them.

## Test plan
- Reset: hold rst=0 with random bit_in and bit_valid, then check every output is 0. Assert rst asynchronously mid-cycle and check outputs clear before the next edge.
- Packing: WIDTH=8, word_ready=1, bits 1,0,1,0,0,1,0,1 on consecutive cycles → word_out=0xA5, word_valid high for one cycle starting the cycle after the 8th bit, fifo_level returns to 0.
- Gaps: same bits with bit_valid=0 for 3 cycles after bits 2 and 5 → word_out=0xA5. bit_pos holds 2 and 5 during the gaps.
- Fill and overflow: DEPTH=4, word_ready=0, push words 0x01,0x02,0x03,0x04,0x05 → fifo_level=4, overflow=1 after the 5th completes. Then drain with word_ready=1 → outputs 0x01..0x04 in order, 0x05 never appears.
- Full with simultaneous pop: FIFO full, word_ready=1 on the edge that completes word 0x3C → no overflow, fifo_level stays 4, 0x3C exits last. Assert clr_ovf and overflow together → set wins; clr_ovf alone clears it.
- Reset mid-word: after 5 bits, pulse rst=0 → bit_pos=0. Then 8 bits of 0xFF → word_out=0xFF with no residue from the discarded bits.
